// File: rtl/video_sink_pkg.sv
// video_sink_pkg
//   Shared definitions for the video sink checker.
//   - sink_state_t : checker FSM states (SYNC_WAIT, ACQUIRE, LOCKED)
//   - CRC_POLY     : CRC-16-CCITT polynomial used by the optional frame CRC
//   - CRC_INIT     : CRC seed applied after reset and at every frame close
package video_sink_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    ACQUIRE   = 2'd1,
    LOCKED    = 2'd2
  } sink_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/video_crc16.sv
// video_crc16
//   One pixel-wide step of CRC-16-CCITT: folds 24 bits of pixel data into the
//   running CRC, most significant bit first. Purely combinational.
//   Only built when VIDEO_SINK_CRC_EN is defined.
//   Ports:
//     crc_in  in  16  running CRC before this pixel
//     data    in  24  pixel {R,G,B}
//     crc_out out 16  running CRC after this pixel
`ifdef VIDEO_SINK_CRC_EN
module video_crc16
  import video_sink_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;
  logic        fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    crc_out = c;
  end

endmodule
`endif

// File: rtl/video_sink_checker.sv
// video_sink_checker
//   Receive-side checker for the video output interface. Recovers line/frame
//   geometry from HS/VS/BLANK, locks when it matches HDISP x VDISP, counts
//   frames and timing errors while locked.
//   Optional feature macro: VIDEO_SINK_CRC_EN (per-frame CRC-16 of active
//   pixels on frame_crc; without it frame_crc is tied to 0).
//   Ports:
//     pixel_clk   in  1   pixel clock
//     pixel_rst   in  1   asynchronous active-high reset
//     vid_hs      in  1   horizontal sync, active low
//     vid_vs      in  1   vertical sync, active low
//     vid_blank   in  1   1 = active pixel
//     vid_rgb     in  24  pixel {R,G,B}
//     locked      out 1   geometry matches HDISP/VDISP
//     frame_done  out 1   one-cycle pulse per completed frame
//     meas_hact   out CW  active pixels of last closed active line
//     meas_vact   out CW  active lines of last closed frame
//     meas_htotal out CW  clocks between last two HS assertions
//     frame_cnt   out 16  completed frames (wrapping)
//     err_cnt     out 8   timing errors while locked (saturating)
//     frame_crc   out 16  CRC of last closed frame
module video_sink_checker
  import video_sink_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int CW    = 12
)(
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          vid_hs,
  input  logic          vid_vs,
  input  logic          vid_blank,
  input  logic [23:0]   vid_rgb,
  output logic          locked,
  output logic          frame_done,
  output logic [CW-1:0] meas_hact,
  output logic [CW-1:0] meas_vact,
  output logic [CW-1:0] meas_htotal,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    err_cnt,
  output logic [15:0]   frame_crc
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] HDISP_C = CW'(HDISP);
  localparam logic [CW-1:0] VDISP_C = CW'(VDISP);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Stage 1: raw input registers
  logic hs_r, vs_r, blank_r;
  // Stage 2: registered sync edges, aligned with the delayed blank
  logic hs_d, vs_d, hs_fall_q, vs_fall_q, blank_q;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      blank_r   <= 1'b0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      hs_fall_q <= 1'b0;
      vs_fall_q <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      hs_r      <= vid_hs;
      vs_r      <= vid_vs;
      blank_r   <= vid_blank;
      hs_d      <= hs_r;
      vs_d      <= vs_r;
      hs_fall_q <= hs_d & ~hs_r;
      vs_fall_q <= vs_d & ~vs_r;
      blank_q   <= blank_r;
    end
  end

  sink_state_t   state;
  logic [CW-1:0] pix_cnt, line_cnt, clk_cnt;
  logic          err_flag;

  // Line/frame close decisions for the current cycle. A line closed in the
  // same cycle as VS is folded into the frame being closed.
  logic          line_act, line_bad, frame_err;
  logic [CW-1:0] lines_total, hact_now;

  always_comb begin
    line_act    = hs_fall_q && (pix_cnt != '0);
    line_bad    = line_act && (pix_cnt != HDISP_C);
    lines_total = line_cnt;
    if (line_act && (line_cnt != CNT_MAX))
      lines_total = line_cnt + 1'b1;
    // Blank (zero-pixel) lines do not overwrite the active-line width, so
    // meas_hact reflects the last active line of the frame.
    hact_now    = line_act ? pix_cnt : meas_hact;
    frame_err   = err_flag || ((state == LOCKED) && line_bad);
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state       <= SYNC_WAIT;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      clk_cnt     <= '0;
      err_flag    <= 1'b0;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      meas_hact   <= '0;
      meas_vact   <= '0;
      meas_htotal <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;

      if (hs_fall_q) begin
        // clk_cnt restarts at 1 so it equals the HS period at the next HS
        meas_htotal <= clk_cnt;
        clk_cnt     <= {{(CW-1){1'b0}}, 1'b1};
        if (line_act)
          meas_hact <= pix_cnt;
        line_cnt <= lines_total;
        err_flag <= frame_err;
        pix_cnt  <= {{(CW-1){1'b0}}, blank_q};
      end else begin
        clk_cnt <= sat_inc(clk_cnt);
        if (blank_q)
          pix_cnt <= sat_inc(pix_cnt);
      end

      if (vs_fall_q) begin
        line_cnt <= '0;
        err_flag <= 1'b0;
        pix_cnt  <= {{(CW-1){1'b0}}, blank_q};
        case (state)
          SYNC_WAIT: begin
            // first VS only aligns us to a frame boundary
            state  <= ACQUIRE;
            locked <= 1'b0;
          end
          ACQUIRE: begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            meas_vact  <= lines_total;
            if ((hact_now == HDISP_C) && (lines_total == VDISP_C)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            meas_vact  <= lines_total;
            if (frame_err || (lines_total != VDISP_C)) begin
              state  <= ACQUIRE;
              locked <= 1'b0;
              if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            end
          end
          default: begin
            state  <= SYNC_WAIT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VIDEO_SINK_CRC_EN
  logic [23:0] rgb_r, rgb_q;
  logic [15:0] crc_reg, crc_step, crc_frame;

  video_crc16 u_crc (
    .crc_in  (crc_reg),
    .data    (rgb_q),
    .crc_out (crc_step)
  );

  // include the pixel of the closing cycle, if any
  assign crc_frame = blank_q ? crc_step : crc_reg;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      rgb_r     <= '0;
      rgb_q     <= '0;
      crc_reg   <= CRC_INIT;
      frame_crc <= '0;
    end else begin
      rgb_r <= vid_rgb;
      rgb_q <= rgb_r;
      if (vs_fall_q) begin
        if (state != SYNC_WAIT)
          frame_crc <= crc_frame;
        crc_reg <= CRC_INIT;
      end else begin
        crc_reg <= crc_frame;
      end
    end
  end
`else
  logic rgb_unused;
  assign rgb_unused = ^vid_rgb;
  assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_video_sink_checker.sv
// tb_video_sink_checker
//   Directed bench for video_sink_checker using a scaled-down panel
//   (16x8 active, HFP4 HS4 HBP4, VFP2 VS2 VBP2: htotal 28, vtotal 14).
//   Define VIDEO_SINK_CRC_EN for both bench and RTL to exercise the CRC.
module tb_video_sink_checker;

  localparam int HDISP = 16;
  localparam int VDISP = 8;
  localparam int CW    = 12;
  localparam int HFP = 4, HSW = 4, HBP = 4;
  localparam int VFP = 2, VSW = 2, VBP = 2;
  localparam int HTOT = HDISP + HFP + HSW + HBP;
  localparam int VTOT = VDISP + VFP + VSW + VBP;
  localparam int FULL = HTOT * VTOT;

  logic          clk = 1'b0;
  logic          rst;
  logic          hs, vs, blank;
  logic [23:0]   rgb;
  logic          locked, frame_done;
  logic [CW-1:0] meas_hact, meas_vact, meas_htotal;
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;
  logic [15:0]   frame_crc;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_pulses = 0;

  always #5 clk = ~clk;

  video_sink_checker #(.HDISP(HDISP), .VDISP(VDISP), .CW(CW)) dut (
    .pixel_clk   (clk),
    .pixel_rst   (rst),
    .vid_hs      (hs),
    .vid_vs      (vs),
    .vid_blank   (blank),
    .vid_rgb     (rgb),
    .locked      (locked),
    .frame_done  (frame_done),
    .meas_hact   (meas_hact),
    .meas_vact   (meas_vact),
    .meas_htotal (meas_htotal),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .frame_crc   (frame_crc)
  );

  always @(negedge clk)
    if (frame_done === 1'b1) fd_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Drives one frame starting at line 0, one pixel per negedge.
  //   act_lines : number of active lines
  //   short_ln  : line carrying HDISP-1 pixels (-1 = none)
  //   align_vs  : VS falls together with HS of the last active line
  //   flip_p    : frame position whose RGB bit 0 is inverted (-1 = none)
  //   ncyc      : number of clocks to drive (FULL = whole frame)
  task automatic send_frame(input int act_lines, input int short_ln, input bit align_vs,
                            input int flip_p, input int ncyc);
    int vs_start;
    vs_start = align_vs ? ((VDISP - 1) * HTOT + HDISP + HFP) : ((VDISP + VFP) * HTOT);
    for (int l = 0; l < VTOT; l++) begin
      for (int c = 0; c < HTOT; c++) begin
        int p;
        int w;
        logic [23:0] px;
        p = l * HTOT + c;
        if (p < ncyc) begin
          w     = (l == short_ln) ? HDISP - 1 : HDISP;
          blank = (l < act_lines) && (c < w);
          hs    = !((c >= HDISP + HFP) && (c < HDISP + HFP + HSW));
          vs    = !((p >= vs_start) && (p < vs_start + VSW * HTOT));
          px    = {8'(l), 8'(c), 8'h5A};
          if (p == flip_p) px[0] = ~px[0];
          rgb   = blank ? px : 24'h0;
          @(negedge clk);
        end
      end
    end
    hs = 1'b1; vs = 1'b1; blank = 1'b0; rgb = 24'h0;
  endtask

  logic [15:0] crc_a, crc_b, crc_c;

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0; rgb = 24'h0;
    #128;
    check_eq("rst_locked", locked, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_hact", meas_hact, 0);
    check_eq("rst_vact", meas_vact, 0);
    check_eq("rst_htotal", meas_htotal, 0);
    check_eq("rst_crc", frame_crc, 0);
    @(negedge clk);
    rst = 1'b0;

    // acquire and lock
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    check_eq("f1_locked", locked, 0);
    check_eq("f1_frame_cnt", frame_cnt, 0);
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    check_eq("f2_locked", locked, 1);
    check_eq("f2_frame_cnt", frame_cnt, 1);
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    check_eq("f4_locked", locked, 1);
    check_eq("f4_hact", meas_hact, HDISP);
    check_eq("f4_vact", meas_vact, VDISP);
    check_eq("f4_htotal", meas_htotal, HTOT);
    check_eq("f4_frame_cnt", frame_cnt, 3);
    check_eq("f4_err_cnt", err_cnt, 0);
    check_eq("f4_pulses", fd_pulses, 3);

    // one short line while locked
    send_frame(VDISP, 3, 1'b0, -1, FULL);
    check_eq("short_line_err", err_cnt, 1);
    check_eq("short_line_locked", locked, 0);
    check_eq("short_line_hact", meas_hact, HDISP);
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    check_eq("relock_locked", locked, 1);
    check_eq("relock_frame_cnt", frame_cnt, 5);

    // frames one active line short
    send_frame(VDISP - 1, -1, 1'b0, -1, FULL);
    check_eq("vshort1_locked", locked, 0);
    check_eq("vshort1_vact", meas_vact, VDISP - 1);
    check_eq("vshort1_err", err_cnt, 2);
    send_frame(VDISP - 1, -1, 1'b0, -1, FULL);
    check_eq("vshort2_locked", locked, 0);
    check_eq("vshort2_vact", meas_vact, VDISP - 1);
    check_eq("vshort2_err", err_cnt, 2);
    check_eq("vshort2_frame_cnt", frame_cnt, 7);
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    check_eq("vgood_locked", locked, 1);
    check_eq("vgood_pulses", fd_pulses, 8);

    // reset in the middle of a frame
    send_frame(VDISP, -1, 1'b0, -1, 150);
    rst = 1'b1;
    #1;
    check_eq("midrst_locked", locked, 0);
    check_eq("midrst_frame_cnt", frame_cnt, 0);
    check_eq("midrst_err_cnt", err_cnt, 0);
    check_eq("midrst_hact", meas_hact, 0);
    check_eq("midrst_vact", meas_vact, 0);
    check_eq("midrst_htotal", meas_htotal, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    check_eq("postrst1_locked", locked, 0);
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    check_eq("postrst2_locked", locked, 1);
    check_eq("postrst2_frame_cnt", frame_cnt, 1);

    // VS coincident with HS of the last active line
    send_frame(VDISP, -1, 1'b1, -1, FULL);
    check_eq("align_vact", meas_vact, VDISP);
    check_eq("align_err", err_cnt, 0);
    check_eq("align_locked", locked, 1);

    // CRC frames: two identical, then one with a flipped bit
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    crc_a = frame_crc;
    send_frame(VDISP, -1, 1'b0, -1, FULL);
    crc_b = frame_crc;
    send_frame(VDISP, -1, 1'b0, 2 * HTOT + 5, FULL);
    crc_c = frame_crc;
`ifdef VIDEO_SINK_CRC_EN
    check_eq("crc_repeat", crc_b, crc_a);
    check_eq("crc_flip_differs", (crc_c != crc_b), 1);
`else
    check_eq("crc_off_a", crc_a, 0);
    check_eq("crc_off_c", crc_c, 0);
`endif
    check_eq("end_frame_cnt", frame_cnt, 5);
    check_eq("end_locked", locked, 1);
    check_eq("end_err_cnt", err_cnt, 0);
    check_eq("end_pulses", fd_pulses, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
